// File: rtl/alarm_pkg.sv
// Shared definitions for the alarm controller: state encoding, time-field
// width and the wrap-around increment used by the alarm time setters.
package alarm_pkg;

  localparam int TIME_W     = 6;
  localparam int MAX_MINSEC = 59;

  // Encoding is visible on state_o, so the values are fixed explicitly.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_RINGING = 2'd2,
    ST_SNOOZE  = 2'd3
  } alarm_state_t;

  // Increment a minutes/seconds field, wrapping 59 -> 0.
  function automatic logic [TIME_W-1:0] inc_wrap(input logic [TIME_W-1:0] val);
    if (val >= TIME_W'(MAX_MINSEC))
      inc_wrap = '0;
    else
      inc_wrap = val + TIME_W'(1);
  endfunction

endpackage

// File: rtl/btn_sync_edge.sv
// Two-flop synchronizer followed by a rising-edge detector. A raw high first
// sampled at edge N yields a pulse that downstream registers see at edge N+2;
// holding the button produces only one pulse.
module btn_sync_edge (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic pulse
);

  logic sync1_reg;
  logic sync2_reg;
  logic prev_reg;

  // Synchronize the raw input and remember the previous synchronized level.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_reg <= 1'b0;
      sync2_reg <= 1'b0;
      prev_reg  <= 1'b0;
    end else begin
      sync1_reg <= raw;
      sync2_reg <= sync1_reg;
      prev_reg  <= sync2_reg;
    end
  end

  assign pulse = sync2_reg & ~prev_reg;

endmodule

// File: rtl/alarm_ctrl.sv
// Alarm controller: holds the user-set alarm time, compares it against the
// running mm:ss on each 1 Hz tick, and drives ring/flash with snooze, stop
// and ring-timeout handling.
module alarm_ctrl
  import alarm_pkg::*;
#(
  parameter int RING_SEC   = 30,
  parameter int SNOOZE_SEC = 10,
  parameter int CNT_W      = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              tick_1hz,
  input  logic [TIME_W-1:0] cur_min,
  input  logic [TIME_W-1:0] cur_sec,
  input  logic              arm_sw,
  input  logic              btn_min_raw,
  input  logic              btn_sec_raw,
  input  logic              btn_snooze_raw,
  input  logic              btn_stop_raw,
  output logic [TIME_W-1:0] alarm_min,
  output logic [TIME_W-1:0] alarm_sec,
  output logic              ring,
  output logic              flash,
  output logic [1:0]        state_o
);

  localparam logic [CNT_W-1:0] RING_LAST   = CNT_W'(RING_SEC - 1);
  localparam logic [CNT_W-1:0] SNOOZE_LAST = CNT_W'(SNOOZE_SEC - 1);

  // Button index map: 0 = minute, 1 = second, 2 = snooze, 3 = stop.
  logic [3:0] raw_vec;
  logic [3:0] pulse_vec;

  assign raw_vec = {btn_stop_raw, btn_snooze_raw, btn_sec_raw, btn_min_raw};

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_btn
      btn_sync_edge u_btn (
        .clk   (clk),
        .reset (reset),
        .raw   (raw_vec[gi]),
        .pulse (pulse_vec[gi])
      );
    end
  endgenerate

  logic min_pulse;
  logic sec_pulse;
  logic snooze_pulse;
  logic stop_pulse;

  assign min_pulse    = pulse_vec[0];
  assign sec_pulse    = pulse_vec[1];
  assign snooze_pulse = pulse_vec[2];
  assign stop_pulse   = pulse_vec[3];

  alarm_state_t      state_reg;
  logic [CNT_W-1:0]  counter_reg;
  logic              ring_reg;
  logic              flash_reg;
  logic [TIME_W-1:0] alarm_min_reg;
  logic [TIME_W-1:0] alarm_sec_reg;

  // Compare uses the current alarm registers, so an edit landing on the same
  // edge as a tick is judged against the pre-increment time.
  logic match;
  assign match = tick_1hz && (cur_min == alarm_min_reg) && (cur_sec == alarm_sec_reg);

  logic edit_ok;
  assign edit_ok = (state_reg == ST_IDLE) || (state_reg == ST_ARMED);

  // Alarm time setters: only while idle or armed; seconds never carry.
  always_ff @(posedge clk) begin
    if (reset) begin
      alarm_min_reg <= '0;
      alarm_sec_reg <= '0;
    end else if (edit_ok) begin
      if (min_pulse)
        alarm_min_reg <= inc_wrap(alarm_min_reg);
      if (sec_pulse)
        alarm_sec_reg <= inc_wrap(alarm_sec_reg);
    end
  end

  // Main FSM with registered ring/flash; disarm overrides every button/tick.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= ST_IDLE;
      counter_reg <= '0;
      ring_reg    <= 1'b0;
      flash_reg   <= 1'b0;
    end else if (!arm_sw) begin
      state_reg   <= ST_IDLE;
      counter_reg <= '0;
      ring_reg    <= 1'b0;
      flash_reg   <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          state_reg <= ST_ARMED;
        end

        ST_ARMED: begin
          if (match) begin
            state_reg   <= ST_RINGING;
            counter_reg <= '0;
            ring_reg    <= 1'b1;
            flash_reg   <= 1'b0;
          end
        end

        ST_RINGING: begin
          if (stop_pulse) begin
            state_reg   <= ST_ARMED;
            counter_reg <= '0;
            ring_reg    <= 1'b0;
            flash_reg   <= 1'b0;
          end else if (snooze_pulse) begin
            state_reg   <= ST_SNOOZE;
            counter_reg <= '0;
            ring_reg    <= 1'b0;
            flash_reg   <= 1'b0;
          end else if (tick_1hz) begin
            if (counter_reg == RING_LAST) begin
              // Timed out: back to armed; a match on this tick is ignored.
              state_reg   <= ST_ARMED;
              counter_reg <= '0;
              ring_reg    <= 1'b0;
              flash_reg   <= 1'b0;
            end else begin
              counter_reg <= counter_reg + CNT_W'(1);
              flash_reg   <= ~flash_reg;
            end
          end
        end

        ST_SNOOZE: begin
          if (stop_pulse) begin
            state_reg   <= ST_ARMED;
            counter_reg <= '0;
            ring_reg    <= 1'b0;
            flash_reg   <= 1'b0;
          end else if (tick_1hz) begin
            if (counter_reg == SNOOZE_LAST) begin
              state_reg   <= ST_RINGING;
              counter_reg <= '0;
              ring_reg    <= 1'b1;
              flash_reg   <= 1'b0;
            end else begin
              counter_reg <= counter_reg + CNT_W'(1);
            end
          end
        end

        default: begin
          state_reg   <= ST_IDLE;
          counter_reg <= '0;
          ring_reg    <= 1'b0;
          flash_reg   <= 1'b0;
        end
      endcase
    end
  end

  assign alarm_min = alarm_min_reg;
  assign alarm_sec = alarm_sec_reg;
  assign ring      = ring_reg;
  assign flash     = flash_reg;
  assign state_o   = state_reg;

endmodule

// File: doc/alarm_ctrl.md
Name: alarm_ctrl

Overview:
- Alarm controller between the mm:ss time counters and the ringtone/flash stage.
- Holds a user-set alarm time and compares it against the running time on each 1 Hz tick.
- Drives `ring` (the SongPlayer play/trigger enable) and `flash`, with snooze, stop and ring-timeout behaviour.
- Exports the alarm time so the display mux can show it.

Parameters:
- RING_SEC, 30, seconds of ringing before auto-stop (1..255).
- SNOOZE_SEC, 10, seconds spent in snooze before ringing resumes (1..255).
- CNT_W, 8, width of the internal seconds counter.

Ports:
- clk  in  1  system clock, 100 MHz.
- reset  in  1  synchronous, active-high.
- tick_1hz  in  1  one-cycle strobe, once per second, synchronous to clk.
- cur_min  in  6  current minutes, binary 0..59.
- cur_sec  in  6  current seconds, binary 0..59.
- arm_sw  in  1  level switch; 1 = alarm enabled.
- btn_min_raw  in  1  raw button; increments alarm minutes.
- btn_sec_raw  in  1  raw button; increments alarm seconds.
- btn_snooze_raw  in  1  raw button; snooze.
- btn_stop_raw  in  1  raw button; stop.
- alarm_min  out  6  alarm minutes, 0..59.
- alarm_sec  out  6  alarm seconds, 0..59.
- ring  out  1  1 while the ringtone must play.
- flash  out  1  display flash, toggles each second while ringing.
- state_o  out  2  current FSM state, for debug/LED.

Behaviour:
- Clock and reset: reset is synchronous and active-high; clock is clk.
- Reset values: FSM=IDLE, alarm_min=0, alarm_sec=0, ring=0, flash=0, counter=0, all sync/edge flops=0.
- Button inputs: each raw button passes through a 2-flop synchronizer plus a rising-edge detector, giving a one-cycle pulse.
  - A raw high first sampled at edge N acts on registers at edge N+2.
  - Holding a button produces exactly one pulse.
- States (encoding): IDLE=0, ARMED=1, RINGING=2, SNOOZE=3.
- Match condition: tick_1hz=1 && cur_min==alarm_min && cur_sec==alarm_sec.
- IDLE:
  - arm_sw=1 -> ARMED.
  - No match detection in IDLE.
- ARMED:
  - match -> RINGING; counter cleared to 0; ring=1 from the next edge (1-cycle latency).
- RINGING:
  - stop pulse -> ARMED.
  - else snooze pulse -> SNOOZE, counter cleared.
  - else on tick: counter+1, flash toggles; when counter reaches RING_SEC-1 and tick occurs -> ARMED (auto-stop after exactly RING_SEC ticks).
- SNOOZE:
  - stop pulse -> ARMED.
  - On tick: counter+1; after SNOOZE_SEC ticks -> RINGING with counter cleared.
  - Matches are ignored in SNOOZE.
- Global overrides:
  - arm_sw=0 forces IDLE from any state next edge; this has priority over all buttons and matches.
  - Priority order: reset > arm_sw=0 > stop > snooze > tick/match.
- Outputs per state:
  - ring=1 only in RINGING.
  - flash=0 outside RINGING; flash is forced to 0 on every exit from RINGING.
- Alarm time setting:
  - Minute pulse: alarm_min+1, wrapping 59->0. Second pulse: alarm_sec+1, wrapping 59->0.
  - Accepted only in IDLE or ARMED; ignored in RINGING and SNOOZE.
  - Second wrap does not carry into minutes.
- Edit coinciding with match: the match compares against pre-increment values (registered compare uses the current register contents).
- Retrigger: after stop or auto-stop the alarm re-fires only at the next time equality (next wrap of the mm:ss counter). A match on the same tick as auto-stop does not retrigger.
- Reset mid-ring: ring and flash drop to 0 at the reset edge; the alarm time returns to 00:00.

Decomposition:
- Shared package `alarm_pkg`: state encoding constants (IDLE/ARMED/RINGING/SNOOZE), MAX_MINSEC=59, time field width 6.
- One sub-module `btn_sync_edge`: 2-flop synchronizer plus rising-edge pulse, instantiated four times.
- FSM, counter and alarm-time registers stay in `alarm_ctrl`.

Test Plan:
- Set and wrap:
  - Stimulus: reset, then 3 btn_sec presses and 60 btn_min presses in IDLE.
  - Required: alarm_sec=3, alarm_min=0 (wrap); each press, even if held 100 cycles, yields +1.
- Fire on match:
  - Stimulus: alarm 00:05, arm_sw=1, drive cur time 00:04 then 00:05 with tick.
  - Required: ring=1 exactly 1 cycle after the 00:05 tick; state_o=2.
- Auto-stop:
  - Stimulus: RING_SEC=30 while ringing, issue 30 ticks.
  - Required: ring=0 and state_o=1 after the 30th tick; flash toggled 29 times, then forced to 0.
- Snooze:
  - Stimulus: snooze press while ringing, then SNOOZE_SEC=10 ticks.
  - Required: ring=0 during snooze; ring=1 again after the 10th tick; a match during snooze is ignored.
- Simultaneous buttons:
  - Stimulus: stop and snooze pressed in the same cycle while ringing.
  - Required: state -> ARMED (stop wins).
- Disarm and reset:
  - Stimulus: arm_sw=0 while ringing.
  - Required: IDLE next edge, ring=0.
  - Stimulus: reset asserted mid-snooze.
  - Required: all outputs 0, alarm time 00:00.
